// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - fetch/decode/control sequencer feeding the 8x8 register file
module instr_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int PC_WIDTH   = 8,
  parameter int PC_STEP    = 4
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [31:0]           INSTR,
  input  logic                  INSTR_VALID,
  output logic                  INSTR_READY,
  output logic [PC_WIDTH-1:0]   PC,
  output logic [ADDR_WIDTH-1:0] READREG1,
  output logic [ADDR_WIDTH-1:0] READREG2,
  output logic [ADDR_WIDTH-1:0] WRITEREG,
  output logic                  WRITE_EN,
  output logic [DATA_WIDTH-1:0] IMMEDIATE,
  output logic [2:0]            ALUOP,
  output logic                  IMM_SEL,
  output logic                  NEG_SEL,
  output logic                  BUSY,
  output logic                  ILLEGAL
);

  localparam logic [7:0] OP_LOADI = 8'h00;
  localparam logic [7:0] OP_MOV   = 8'h01;
  localparam logic [7:0] OP_ADD   = 8'h02;
  localparam logic [7:0] OP_SUB   = 8'h03;
  localparam logic [7:0] OP_AND   = 8'h04;
  localparam logic [7:0] OP_OR    = 8'h05;

  localparam logic [2:0] ALU_FWD = 3'b000;
  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;

  typedef enum logic [1:0] {IDLE, DECODE, EXEC, WB} state_t;

  state_t state;
  state_t nextState;

  logic [7:0] opcode;
  logic [7:0] destField;
  logic [7:0] src1Field;
  logic [7:0] src2Field;

  logic [2:0] decAluOp;
  logic       decImmSel;
  logic       decNegSel;
  logic       opLegal;
  logic       decIllegal;
  logic       transfer;

  // Illegal flag of the instruction in flight; only consulted when entering WB.
  logic       illegalPending;

  assign opcode    = INSTR[31:24];
  assign destField = INSTR[23:16];
  assign src1Field = INSTR[15:8];
  assign src2Field = INSTR[7:0];

  // A transfer only happens from IDLE, which is exactly when INSTR_READY is high.
  assign transfer = (state == IDLE) && INSTR_VALID;

  // Opcode decode into ALU control plus legality of opcode and register fields.
  always_comb begin
    decAluOp  = ALU_FWD;
    decImmSel = 1'b0;
    decNegSel = 1'b0;
    opLegal   = 1'b1;
    case (opcode)
      OP_LOADI: decImmSel = 1'b1;
      OP_MOV:   decAluOp  = ALU_FWD;
      OP_ADD:   decAluOp  = ALU_ADD;
      OP_SUB: begin
        decAluOp  = ALU_ADD;
        decNegSel = 1'b1;
      end
      OP_AND:   decAluOp  = ALU_AND;
      OP_OR:    decAluOp  = ALU_OR;
      default:  opLegal   = 1'b0;
    endcase
    // src2 is an immediate for loadi, so its upper bits are only checked otherwise.
    decIllegal = !opLegal
              || (|destField[7:ADDR_WIDTH])
              || (|src1Field[7:ADDR_WIDTH])
              || ((opcode != OP_LOADI) && (|src2Field[7:ADDR_WIDTH]));
  end

  // State register.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic: fixed four-cycle walk once an instruction is taken.
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (INSTR_VALID) nextState = DECODE;
      DECODE:  nextState = EXEC;
      EXEC:    nextState = WB;
      WB:      nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Registered outputs, computed from the upcoming state so they line up with it.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      INSTR_READY    <= 1'b1;
      BUSY           <= 1'b0;
      WRITE_EN       <= 1'b0;
      ILLEGAL        <= 1'b0;
      PC             <= '0;
      READREG1       <= '0;
      READREG2       <= '0;
      WRITEREG       <= '0;
      IMMEDIATE      <= '0;
      ALUOP          <= ALU_FWD;
      IMM_SEL        <= 1'b0;
      NEG_SEL        <= 1'b0;
      illegalPending <= 1'b0;
    end else begin
      INSTR_READY <= (nextState == IDLE);
      BUSY        <= (nextState != IDLE);
      WRITE_EN    <= (nextState == WB) && !illegalPending;
      if ((nextState == WB) && illegalPending) begin
        ILLEGAL <= 1'b1;
      end
      if (transfer) begin
        PC             <= PC + PC_WIDTH'(PC_STEP);
        READREG1       <= src1Field[ADDR_WIDTH-1:0];
        READREG2       <= src2Field[ADDR_WIDTH-1:0];
        WRITEREG       <= destField[ADDR_WIDTH-1:0];
        IMMEDIATE      <= INSTR[DATA_WIDTH-1:0];
        ALUOP          <= decAluOp;
        IMM_SEL        <= decImmSel;
        NEG_SEL        <= decNegSel;
        illegalPending <= decIllegal;
      end
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - scoreboard bench for instr_sequencer with random and directed stimulus
module tb_instr_sequencer;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic [31:0] INSTR = '0;
  logic        INSTR_VALID = 1'b0;
  logic        INSTR_READY;
  logic [7:0]  PC;
  logic [2:0]  READREG1, READREG2, WRITEREG;
  logic        WRITE_EN;
  logic [7:0]  IMMEDIATE;
  logic [2:0]  ALUOP;
  logic        IMM_SEL, NEG_SEL, BUSY, ILLEGAL;

  instr_sequencer dut (
    .CLK(CLK), .RESET(RESET), .INSTR(INSTR), .INSTR_VALID(INSTR_VALID),
    .INSTR_READY(INSTR_READY), .PC(PC), .READREG1(READREG1), .READREG2(READREG2),
    .WRITEREG(WRITEREG), .WRITE_EN(WRITE_EN), .IMMEDIATE(IMMEDIATE), .ALUOP(ALUOP),
    .IMM_SEL(IMM_SEL), .NEG_SEL(NEG_SEL), .BUSY(BUSY), .ILLEGAL(ILLEGAL)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] pc;
    logic [2:0] rr1, rr2, wr;
    logic [7:0] imm;
    logic [2:0] aluop;
    logic       immSel, negSel, opLegal, illegal, sticky;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cycle = 0;
  int   pcModel = 0;
  bit   stickyModel = 1'b0;
  bit   monOn = 1'b0;
  int   lastAccept = 0;
  int   prevAccept = 0;

  always @(posedge CLK) cycle <= cycle + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Reference model: derives the expected decode from the instruction table.
  task automatic pushExpected(input logic [31:0] ins);
    exp_t e;
    logic [7:0] op, d, s1, s2;
    op = ins[31:24]; d = ins[23:16]; s1 = ins[15:8]; s2 = ins[7:0];
    e.opLegal = (op <= 8'd5);
    e.illegal = !e.opLegal || (d > 8'd7) || (s1 > 8'd7) || ((op != 8'd0) && (s2 > 8'd7));
    case (op)
      8'd2, 8'd3: e.aluop = 3'd1;
      8'd4:       e.aluop = 3'd2;
      8'd5:       e.aluop = 3'd3;
      default:    e.aluop = 3'd0;
    endcase
    e.immSel = (op == 8'd0);
    e.negSel = (op == 8'd3);
    e.rr1 = s1[2:0]; e.rr2 = s2[2:0]; e.wr = d[2:0]; e.imm = s2;
    pcModel = (pcModel + 4) % 256;
    e.pc = pcModel[7:0];
    stickyModel = stickyModel | e.illegal;
    e.sticky = stickyModel;
    sb.push_back(e);
  endtask

  function automatic logic [31:0] randInstr();
    logic [7:0] f[4];
    f[0] = 8'($urandom % 8);
    for (int i = 1; i < 4; i++)
      f[i] = (($urandom % 16) == 0) ? 8'($urandom % 256) : 8'($urandom % 8);
    if (f[0] == 8'd0) f[3] = 8'($urandom % 256);
    return {f[0], f[1], f[2], f[3]};
  endfunction

  // Monitor: on each instruction's return to idle, pop and compare against the model.
  int busyCnt = 0, weCnt = 0, wePos = 0;
  bit prevBusy = 1'b0;
  always @(negedge CLK) begin
    if (!monOn) begin
      busyCnt = 0; weCnt = 0; wePos = 0; prevBusy = 1'b0;
    end else begin
      if (BUSY) begin
        busyCnt++;
        if (WRITE_EN) begin weCnt++; wePos = busyCnt; end
      end else begin
        check("we_idle", WRITE_EN, 1'b0);
        if (prevBusy) begin
          if (sb.size() == 0) begin
            check("sb_underflow", 1, 0);
          end else begin
            exp_t e;
            e = sb.pop_front();
            check("pc", PC, e.pc);
            check("readreg1", READREG1, e.rr1);
            check("readreg2", READREG2, e.rr2);
            check("writereg", WRITEREG, e.wr);
            check("immediate", IMMEDIATE, e.imm);
            if (e.opLegal) begin
              check("aluop", ALUOP, e.aluop);
              check("imm_sel", IMM_SEL, e.immSel);
              check("neg_sel", NEG_SEL, e.negSel);
            end
            check("illegal", ILLEGAL, e.sticky);
            check("busy_cycles", busyCnt, 3);
            check("we_count", weCnt, e.illegal ? 0 : 1);
            if (!e.illegal) check("we_position", wePos, 3);
          end
          busyCnt = 0; weCnt = 0; wePos = 0;
        end
      end
      prevBusy = BUSY;
    end
  end

  // Called at a negedge; returns at the next negedge after the instruction is offered.
  task automatic sendInstr(input logic [31:0] ins, input bit keepValid);
    int w = 0;
    while (!INSTR_READY && w < 50) begin @(negedge CLK); w++; end
    check("ready_timeout", (w < 50), 1);
    INSTR = ins;
    INSTR_VALID = 1'b1;
    pushExpected(ins);
    prevAccept = lastAccept;
    lastAccept = cycle;
    @(negedge CLK);
    if (!keepValid) INSTR_VALID = 1'b0;
  endtask

  task automatic waitIdle();
    int w = 0;
    while ((sb.size() != 0 || BUSY) && w < 100) begin @(negedge CLK); w++; end
    check("drain_timeout", (w < 100), 1);
  endtask

  task automatic doReset();
    monOn = 1'b0;
    INSTR_VALID = 1'b0;
    RESET = 1'b0;
    sb.delete();
    pcModel = 0;
    stickyModel = 1'b0;
    repeat (2) @(negedge CLK);
    check("rst_pc", PC, 8'h00);
    check("rst_ready", INSTR_READY, 1'b1);
    check("rst_we", WRITE_EN, 1'b0);
    check("rst_illegal", ILLEGAL, 1'b0);
    check("rst_busy", BUSY, 1'b0);
    RESET = 1'b1;
    @(negedge CLK);
    monOn = 1'b1;
  endtask

  initial begin
    @(negedge CLK);
    doReset();

    // loadi
    sendInstr(32'h0004000A, 1'b0);
    waitIdle();
    check("loadi_pc", PC, 8'h04);

    // sub then add back-to-back with VALID held
    sendInstr(32'h03050102, 1'b1);
    sendInstr(32'h02010203, 1'b0);
    check("b2b_gap", lastAccept - prevAccept, 4);
    waitIdle();
    check("b2b_pc", PC, 8'h0C);

    // illegal opcode, then a legal instruction keeps ILLEGAL set
    sendInstr(32'h07010203, 1'b0);
    sendInstr(32'h01020300, 1'b0);
    waitIdle();
    check("illegal_sticky", ILLEGAL, 1'b1);

    // illegal dest field
    doReset();
    sendInstr(32'h02090102, 1'b0);
    waitIdle();
    check("illegal_dest", ILLEGAL, 1'b1);

    // PC wrap after 64 instructions
    doReset();
    for (int i = 0; i < 64; i++) sendInstr(32'h01000000 | (32'(i % 8) << 16), 1'b1);
    INSTR_VALID = 1'b0;
    waitIdle();
    check("pc_wrap", PC, 8'h00);

    // randomized traffic with idle gaps and junk on INSTR while busy
    doReset();
    for (int n = 0; n < 300; ) begin
      if (INSTR_READY && ($urandom % 4) != 0) begin
        INSTR = randInstr();
        INSTR_VALID = 1'b1;
        pushExpected(INSTR);
        n++;
      end else if (INSTR_READY) begin
        INSTR_VALID = 1'b0;
        INSTR = $urandom;
      end else begin
        INSTR_VALID = 1'($urandom % 2);
        INSTR = $urandom;
      end
      @(negedge CLK);
    end
    INSTR_VALID = 1'b0;
    waitIdle();

    // reset asserted during EXEC of a legal add
    doReset();
    monOn = 1'b0;
    sendInstr(32'h02010203, 1'b0);
    sb.delete();
    @(negedge CLK);
    check("midrst_busy_before", BUSY, 1'b1);
    #2 RESET = 1'b0;
    #1;
    check("midrst_we", WRITE_EN, 1'b0);
    check("midrst_busy", BUSY, 1'b0);
    check("midrst_pc", PC, 8'h00);
    check("midrst_ready", INSTR_READY, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      check("midrst_we_hold", WRITE_EN, 1'b0);
    end
    RESET = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      check("midrst_we_after", WRITE_EN, 1'b0);
    end
    check("midrst_pc_after", PC, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
